// File: rtl/fsm_send_multi.sv
// Multi-word send sequencer: starts the summer, then sends each result as NUM_WORDS UART words
// paced by tx_busy and a minimum gap. Define FSM_SEND_HDR_EN to prefix every frame with a header word.
module fsm_send_multi #(
  parameter int NUM_WORDS  = 2,
  parameter int SEL_W      = 2,
  parameter int GAP_CYCLES = 100,
  parameter int TIMER_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_send,
  input  logic             sum_ready,
  input  logic             tx_busy,
  output logic             sum_en,
  output logic             tx_send,
  output logic [SEL_W-1:0] send_sel,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SUM = 2'd1,
    SEND     = 2'd2,
    WAIT_TX  = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_WORDS - 1);
  localparam logic [SEL_W-1:0]   HDR_IDX  = SEL_W'(NUM_WORDS);
  localparam logic [TIMER_W-1:0] GAP      = TIMER_W'(GAP_CYCLES);

`ifdef FSM_SEND_HDR_EN
  localparam logic [SEL_W-1:0] FIRST_IDX = HDR_IDX;
`else
  localparam logic [SEL_W-1:0] FIRST_IDX = '0;
`endif

  state_t             state_reg;
  logic [SEL_W-1:0]   idx_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               tx_exit;
  logic               last_word;

  // A word is released only when the UART is idle and the gap has elapsed in the same cycle.
  assign tx_exit   = (state_reg == WAIT_TX) && !tx_busy && (timer_reg >= GAP);
  assign last_word = (idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      timer_reg <= '0;
    end else begin
      if (timer_reg != '1) timer_reg <= timer_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (en_send) begin
            state_reg <= WAIT_SUM;
            idx_reg   <= '0;
            timer_reg <= '0;
          end
        end
        WAIT_SUM: begin
          if (sum_ready) begin
            state_reg <= SEND;
            idx_reg   <= FIRST_IDX;
            timer_reg <= '0;
          end
        end
        SEND: begin
          state_reg <= WAIT_TX;
          timer_reg <= '0;
        end
        WAIT_TX: begin
          if (tx_exit) begin
            timer_reg <= '0;
            if (last_word) begin
              idx_reg   <= '0;
              state_reg <= en_send ? WAIT_SUM : IDLE;
            end else begin
              // The header index wraps to the first data word; data words simply advance.
              idx_reg   <= (idx_reg == HDR_IDX) ? '0 : idx_reg + 1'b1;
              state_reg <= SEND;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          idx_reg   <= '0;
          timer_reg <= '0;
        end
      endcase
    end
  end

  assign sum_en     = (state_reg == WAIT_SUM);
  assign tx_send    = (state_reg == SEND);
  assign send_sel   = ((state_reg == SEND) || (state_reg == WAIT_TX)) ? idx_reg : '0;
  assign frame_done = tx_exit && last_word;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fsm_send_multi.sv
// Scoreboard bench for fsm_send_multi: expected send_sel values are queued per frame and
// popped as tx_send pulses appear; cycle spacing and frame_done timing are checked per scenario.
module tb_fsm_send_multi;

  localparam int NUM_WORDS  = 2;
  localparam int SEL_W      = 2;
  localparam int GAP_CYCLES = 100;
  localparam int TIMER_W    = 16;
  localparam int PERIOD     = GAP_CYCLES + 2;
  localparam int BIG        = 1 << 30;
`ifdef FSM_SEND_HDR_EN
  localparam int F = NUM_WORDS + 1;
`else
  localparam int F = NUM_WORDS;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             en_send;
  logic             sum_ready;
  logic             tx_busy;
  logic             sum_en;
  logic             tx_send;
  logic [SEL_W-1:0] send_sel;
  logic             frame_done;
  logic             busy;

  fsm_send_multi #(
    .NUM_WORDS(NUM_WORDS), .SEL_W(SEL_W), .GAP_CYCLES(GAP_CYCLES), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .reset(reset), .en_send(en_send), .sum_ready(sum_ready), .tx_busy(tx_busy),
    .sum_en(sum_en), .tx_send(tx_send), .send_sel(send_sel), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int send_cyc[$];
  int sel_q[$];
  int done_cyc[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
`ifdef FSM_SEND_HDR_EN
    exp_q.push_back(NUM_WORDS);
`endif
    for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back(i);
  endtask

  // Runs ncyc cycles, shaping inputs per cycle and logging tx_send / frame_done events.
  task automatic observe(input int ncyc, input int busy_from, input int busy_to,
                         input int en_drop, input int sr_at);
    send_cyc.delete();
    sel_q.delete();
    done_cyc.delete();
    for (int c = 1; c <= ncyc; c++) begin
      step();
      sum_ready = (c == sr_at);
      tx_busy   = (c >= busy_from) && (c < busy_to);
      if (c >= en_drop) en_send = 1'b0;
      if (tx_send) begin
        send_cyc.push_back(c);
        sel_q.push_back(int'(send_sel));
        $display("cyc %0d: tx_send send_sel=%0d", c, send_sel);
      end
      if (frame_done) begin
        done_cyc.push_back(c);
        $display("cyc %0d: frame_done", c);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en_send = 1'b1; sum_ready = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({sum_en, tx_send, send_sel, frame_done, busy} !== '0)
        $display("FAIL reset_outputs cycle %0d: got %b expected 0", i,
                 {sum_en, tx_send, send_sel, frame_done, busy});
      else n_pass++;
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (sum_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_release: sum_en=%b busy=%b expected 1 1", sum_en, busy);
    else n_pass++;
  endtask

  task automatic test_frame();
    sum_ready = 1'b1;
    push_frame();
    observe(PERIOD * F + 10, 0, 0, BIG, -1);
    n_checks++;
    if (send_cyc.size() != F) $display("FAIL frame_send_count: got %0d expected %0d", send_cyc.size(), F);
    else n_pass++;
    foreach (sel_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL frame_sel[%0d]: got %0d expected none", i, sel_q[i]);
      else begin
        int e = exp_q.pop_front();
        if (sel_q[i] !== e) $display("FAIL frame_sel[%0d]: got %0d expected %0d", i, sel_q[i], e);
        else n_pass++;
      end
    end
    n_checks++;
    if (send_cyc.size() < 1 || send_cyc[0] != 1)
      $display("FAIL frame_first_latency: got %0d expected 1", send_cyc.size() ? send_cyc[0] : -1);
    else n_pass++;
    for (int i = 1; i < send_cyc.size(); i++) begin
      n_checks++;
      if (send_cyc[i] - send_cyc[i-1] != PERIOD)
        $display("FAIL frame_spacing[%0d]: got %0d expected %0d", i, send_cyc[i] - send_cyc[i-1], PERIOD);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() != 1 || send_cyc.size() == 0 || done_cyc[0] != send_cyc[send_cyc.size()-1] + GAP_CYCLES + 1)
      $display("FAIL frame_done_timing: got count %0d first %0d expected 1 at %0d", done_cyc.size(),
               done_cyc.size() ? done_cyc[0] : -1, 1 + PERIOD * (F - 1) + GAP_CYCLES + 1);
    else n_pass++;
    n_checks++;
    if (sum_en !== 1'b1) $display("FAIL frame_rearm: sum_en=%b expected 1", sum_en);
    else n_pass++;
  endtask

  task automatic test_busy_hold();
    sum_ready = 1'b1;
    push_frame();
    observe(310 + PERIOD * F, 2, 302, BIG, -1);
    foreach (sel_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL busy_sel[%0d]: got %0d expected none", i, sel_q[i]);
      else begin
        int e = exp_q.pop_front();
        if (sel_q[i] !== e) $display("FAIL busy_sel[%0d]: got %0d expected %0d", i, sel_q[i], e);
        else n_pass++;
      end
    end
    n_checks++;
    if (send_cyc.size() < 2 || send_cyc[1] != 303)
      $display("FAIL busy_second_send: got %0d expected 303", send_cyc.size() > 1 ? send_cyc[1] : -1);
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1) $display("FAIL busy_done_count: got %0d expected 1", done_cyc.size());
    else n_pass++;
  endtask

  task automatic test_stop();
    sum_ready = 1'b1;
    push_frame();
    observe(PERIOD * F + 10, 0, 0, 50, -1);
    foreach (sel_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL stop_sel[%0d]: got %0d expected none", i, sel_q[i]);
      else begin
        int e = exp_q.pop_front();
        if (sel_q[i] !== e) $display("FAIL stop_sel[%0d]: got %0d expected %0d", i, sel_q[i], e);
        else n_pass++;
      end
    end
    n_checks++;
    if (send_cyc.size() != F || done_cyc.size() != 1)
      $display("FAIL stop_full_frame: sends=%0d done=%0d expected %0d 1", send_cyc.size(), done_cyc.size(), F);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || sum_en !== 1'b0)
      $display("FAIL stop_idle: busy=%b sum_en=%b expected 0 0", busy, sum_en);
    else n_pass++;
    en_send = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    sum_ready = 1'b1;
    push_frame();
    push_frame();
    observe(2 * PERIOD * F + 20, 0, 0, BIG, PERIOD * F + 1);
    foreach (sel_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL b2b_sel[%0d]: got %0d expected none", i, sel_q[i]);
      else begin
        int e = exp_q.pop_front();
        if (sel_q[i] !== e) $display("FAIL b2b_sel[%0d]: got %0d expected %0d", i, sel_q[i], e);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d words unsent expected 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 2 || send_cyc.size() != 2 * F || send_cyc[F] != done_cyc[0] + 2)
      $display("FAIL b2b_restart: done=%0d sends=%0d expected 2 %0d with restart 2 cycles after first done",
               done_cyc.size(), send_cyc.size(), 2 * F);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    sum_ready = 1'b1;
    push_frame();
    observe(150, 0, 0, BIG, -1);
    foreach (sel_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL mid_sel[%0d]: got %0d expected none", i, sel_q[i]);
      else begin
        int e = exp_q.pop_front();
        if (sel_q[i] !== e) $display("FAIL mid_sel[%0d]: got %0d expected %0d", i, sel_q[i], e);
        else n_pass++;
      end
    end
    exp_q.delete();
    reset = 1'b1;
    en_send = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || send_sel !== '0 || frame_done !== 1'b0 || tx_send !== 1'b0)
      $display("FAIL mid_reset: busy=%b send_sel=%0d frame_done=%b tx_send=%b expected all 0",
               busy, send_sel, frame_done, tx_send);
    else n_pass++;
    reset = 1'b0;
    observe(20, 0, 0, BIG, 5);
    n_checks++;
    if (send_cyc.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0)
      $display("FAIL idle_ignores_sum_ready: sends=%0d done=%0d busy=%b expected 0 0 0",
               send_cyc.size(), done_cyc.size(), busy);
    else n_pass++;
    en_send = 1'b1;
    step();
    sum_ready = 1'b1;
    push_frame();
    observe(PERIOD * F + 10, 0, 0, BIG, 50);
    foreach (sel_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL waittx_sel[%0d]: got %0d expected none", i, sel_q[i]);
      else begin
        int e = exp_q.pop_front();
        if (sel_q[i] !== e) $display("FAIL waittx_sel[%0d]: got %0d expected %0d", i, sel_q[i], e);
        else n_pass++;
      end
    end
    n_checks++;
    if (send_cyc.size() != F || done_cyc.size() != 1)
      $display("FAIL waittx_ignores_sum_ready: sends=%0d done=%0d expected %0d 1",
               send_cyc.size(), done_cyc.size(), F);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_busy_hold();
    test_stop();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_send_multi.md
Name: fsm_send_multi

Overview:
Parametrised successor to the single-word send sequencer, sitting between FSM_Mode, the averager/summer and the UART TX.
- On enable, starts the summer and waits for a result.
- Sends the result as NUM_WORDS consecutive UART words, stepping send_sel through word indices.
- Paces each word with a tx_busy handshake plus a minimum inter-word gap.
- Supports continuous operation or a clean stop when en_send drops.

Parameters:
NUM_WORDS, 2, words per result frame (1..2**SEL_W-1)
SEL_W, 2, width of send_sel
GAP_CYCLES, 100, minimum cycles spent in WAIT_TX per word
TIMER_W, 16, width of internal gap timer (GAP_CYCLES < 2**TIMER_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en_send  in  1  run request from FSM_Mode (level)
sum_ready  in  1  summer result valid
tx_busy  in  1  UART transmitter busy
sum_en  out  1  summer enable
tx_send  out  1  one-cycle UART start pulse
send_sel  out  SEL_W  index of word to transmit
frame_done  out  1  one-cycle pulse, frame fully sent
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Registered state and counters: state, word index idx (SEL_W), timer (TIMER_W). All outputs are decoded combinationally from these.
- Reset: state=IDLE, idx=0, timer=0, so every output is 0.
- Timer:
  - Clears to 0 on any state change.
  - Otherwise increments, saturating at all-ones (no wrap).
- IDLE:
  - Outputs low.
  - en_send=1 -> WAIT_SUM, idx<=0.
- WAIT_SUM:
  - sum_en=1.
  - sum_ready=1 -> SEND.
  - sum_ready is ignored in every other state.
- SEND (exactly 1 cycle):
  - tx_send=1, send_sel=idx.
  - Next state WAIT_TX.
- WAIT_TX:
  - send_sel=idx.
  - Exits only when tx_busy=0 and timer>=GAP_CYCLES; both must hold in the same cycle.
  - On exit with idx<NUM_WORDS-1: idx<=idx+1 -> SEND.
  - On exit with idx==NUM_WORDS-1: frame_done=1 that cycle, idx<=0. Then en_send=1 -> WAIT_SUM; en_send=0 -> IDLE.
- en_send is sampled only in IDLE and on the last-word exit. Dropping it mid-frame never truncates a frame.
- send_sel=0 outside SEND/WAIT_TX.
- Latency: en_send high in IDLE -> sum_en high on the next cycle. sum_ready -> tx_send on the next cycle.
- Minimum per-word period: GAP_CYCLES+2 cycles (SEND + WAIT_TX).
- Any undefined state encoding -> IDLE on the next cycle.
- Reset mid-frame: returns to IDLE next edge, no frame_done pulse, idx=0.
- NUM_WORDS=1 degenerates to the single-word sequence with the handshake added.

Optional Feature:
FSM_SEND_HDR_EN
- Defined:
  - Each frame is prefixed by a header word: SEND/WAIT_TX with send_sel = NUM_WORDS (all-ones when NUM_WORDS = 2**SEL_W-1).
  - The header is sent before idx 0, with identical handshake and gap rules.
  - Frame length becomes NUM_WORDS+1 words; frame_done follows the last data word.
- Undefined: no header; frame is exactly NUM_WORDS words as above.

Test Plan:
1. Reset held 3 cycles while en_send=1 -> all outputs 0, busy=0. Release -> sum_en=1 on the next cycle.
2. NUM_WORDS=2, GAP_CYCLES=100, tx_busy=0, en_send=1, sum_ready pulsed once -> tx_send pulses with send_sel=0 then 1, spaced 102 cycles. frame_done pulses at the second WAIT_TX exit, then sum_en=1 again.
3. tx_busy held high 300 cycles after the first tx_send -> WAIT_TX persists until tx_busy falls. Second tx_send comes 1 cycle after the tx_busy fall, not at timer=100.
4. en_send dropped during word 0 of a frame -> word 1 still sent, frame_done pulses, state returns to IDLE, busy=0, sum_en stays 0.
5. Reset asserted in WAIT_TX of word 1 -> next cycle IDLE, send_sel=0, no frame_done. sum_ready pulses while in IDLE or WAIT_TX -> no tx_send.
6. FSM_SEND_HDR_EN defined, NUM_WORDS=2 -> send_sel sequence 2,0,1 with three tx_send pulses per frame and one frame_done.
